// File: rtl/bcd_updown_counter_n_if.sv
// Control/status bundle of the BCD up/down counter. The master side drives the
// count controls; the slave side (the counter) returns the count and the event flags.
interface bcd_updown_counter_n_if #(
    parameter int W = 8
);
    logic         enable;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         dir;
    logic         at_hi;
    logic         at_lo;
    logic         wrap;
    logic         load_err;

    modport master (
        output enable, mode, load, load_val,
        input  count, dir, at_hi, at_lo, wrap, load_err
    );

    modport slave (
        input  enable, mode, load, load_val,
        output count, dir, at_hi, at_lo, wrap, load_err
    );
endinterface

// File: rtl/bcd_updown_counter_n.sv
// Multi-digit packed-BCD counter with programmable limits: up-wrap, down-wrap,
// bounce and hold modes, validated parallel load, registered wrap/load-error pulses.
module bcd_updown_counter_n #(
    parameter int                  DIGITS   = 2,
    parameter logic [4*DIGITS-1:0] LIMIT_LO = 'h00,
    parameter logic [4*DIGITS-1:0] LIMIT_HI = 'h31
) (
    input  logic                  clk,
    input  logic                  reset_n,
    bcd_updown_counter_n_if.slave bus
);
    localparam int           W          = 4 * DIGITS;
    localparam bit           DEGENERATE = (LIMIT_LO == LIMIT_HI);
    localparam logic [W-1:0] SPAN       = LIMIT_HI - LIMIT_LO;

    typedef enum logic [1:0] {
        MODE_UP     = 2'b00,
        MODE_DOWN   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    mode_e             mode;
    logic [W-1:0]      count_q, count_d;
    dir_e              dir_q, dir_d;
    logic              wrap_q, wrap_d;
    logic              load_err_q, load_err_d;
    logic              at_hi, at_lo;

    logic [W-1:0]      count_inc, count_dec;
    logic [DIGITS-1:0] carry, borrow;
    logic [DIGITS-1:0] nibble_ok;
    logic [W:0]        load_offset;
    logic              load_ok;

    assign mode  = mode_e'(bus.mode);
    assign at_hi = (count_q == LIMIT_HI);
    assign at_lo = (count_q == LIMIT_LO);

    // carry[i] / borrow[i]: every digit below i is 9 / 0, so digit i moves on this step.
    assign carry[0]  = 1'b1;
    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] digit;

        assign digit        = count_q[4*i +: 4];
        assign nibble_ok[i] = (bus.load_val[4*i +: 4] <= 4'd9);

        assign count_inc[4*i +: 4] = !carry[i]         ? digit :
                                     (digit == 4'd9)   ? 4'd0  : digit + 4'd1;
        assign count_dec[4*i +: 4] = !borrow[i]        ? digit :
                                     (digit == 4'd0)   ? 4'd9  : digit - 4'd1;

        if (i < DIGITS - 1) begin : g_chain
            assign carry[i+1]  = carry[i]  & (digit == 4'd9);
            assign borrow[i+1] = borrow[i] & (digit == 4'd0);
        end
    end

    // Valid BCD orders like binary, so one offset compare covers both limits:
    // a value below LIMIT_LO wraps the offset far above SPAN.
    assign load_offset = {1'b0, bus.load_val} - {1'b0, LIMIT_LO};
    assign load_ok     = (&nibble_ok) && (load_offset <= {1'b0, SPAN});

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        count_d    = count_q;
        dir_d      = dir_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;

        if (bus.load) begin
            if (load_ok) begin
                count_d = bus.load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.enable && (mode != MODE_HOLD)) begin
            if (DEGENERATE) begin
                wrap_d = 1'b1;
            end else begin
                case (mode)
                    MODE_UP: begin
                        dir_d = DIR_UP;
                        if (at_hi) begin
                            count_d = LIMIT_LO;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_inc;
                        end
                    end
                    MODE_DOWN: begin
                        dir_d = DIR_DOWN;
                        if (at_lo) begin
                            count_d = LIMIT_HI;
                            wrap_d  = 1'b1;
                        end else begin
                            count_d = count_dec;
                        end
                    end
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_UP) begin
                            if (at_hi) begin
                                count_d = count_dec;
                                dir_d   = DIR_DOWN;
                                wrap_d  = 1'b1;
                            end else begin
                                count_d = count_inc;
                            end
                        end else begin
                            if (at_lo) begin
                                count_d = count_inc;
                                dir_d   = DIR_UP;
                                wrap_d  = 1'b1;
                            end else begin
                                count_d = count_dec;
                            end
                        end
                    end
                    MODE_HOLD: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!reset_n) begin
            count_q    <= LIMIT_LO;
            dir_q      <= DIR_UP;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            dir_q      <= dir_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.count    = count_q;
    assign bus.dir      = dir_q;
    assign bus.at_hi    = at_hi;
    assign bus.at_lo    = at_lo;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: three instances (2-digit, 3-digit, degenerate)
// checked against an integer-arithmetic reference model.
module tb_bcd_updown_counter_n;
    logic clk = 1'b0;
    logic reset_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    bcd_updown_counter_n_if #(.W(8))  bus_a ();
    bcd_updown_counter_n_if #(.W(12)) bus_b ();
    bcd_updown_counter_n_if #(.W(4))  bus_c ();

    bcd_updown_counter_n #(.DIGITS(2), .LIMIT_LO(8'h00), .LIMIT_HI(8'h31))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    bcd_updown_counter_n #(.DIGITS(3), .LIMIT_LO(12'h095), .LIMIT_HI(12'h210))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));
    bcd_updown_counter_n #(.DIGITS(1), .LIMIT_LO(4'h5), .LIMIT_HI(4'h5))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(bus_c));

    // Reference model: count kept as a plain decimal integer per instance.
    int lo_v [3] = '{0, 95, 5};
    int hi_v [3] = '{31, 210, 5};
    int dg_v [3] = '{2, 3, 1};
    int m_cnt [3];
    bit m_dir [3];

    logic [11:0] o_cnt;
    logic        o_dir, o_wrap, o_err, o_hi, o_lo;

    function automatic logic [11:0] int2bcd(input int n, input int digits);
        logic [11:0] r = '0;
        int          v = n;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [11:0] b, input int digits);
        int r = 0;
        for (int i = digits - 1; i >= 0; i--) r = r * 10 + int'(b[4*i +: 4]);
        return r;
    endfunction

    function automatic bit digits_ok(input logic [11:0] b, input int digits);
        bit ok = 1'b1;
        for (int i = 0; i < digits; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 3; w++) begin
            m_cnt[w] = lo_v[w];
            m_dir[w] = 1'b1;
        end
    endtask

    task automatic model_step(input int w, input logic en, input logic [1:0] md,
                              input logic ld, input logic [11:0] val,
                              output bit exp_wrap, output bit exp_err);
        int lo = lo_v[w];
        int hi = hi_v[w];
        int v  = bcd2int(val, dg_v[w]);
        exp_wrap = 1'b0;
        exp_err  = 1'b0;
        if (ld) begin
            if (digits_ok(val, dg_v[w]) && v >= lo && v <= hi) m_cnt[w] = v;
            else exp_err = 1'b1;
        end else if (en && md != 2'b11) begin
            if (lo == hi) begin
                exp_wrap = 1'b1;
            end else if (md == 2'b00) begin
                m_dir[w] = 1'b1;
                if (m_cnt[w] == hi) begin m_cnt[w] = lo; exp_wrap = 1'b1; end
                else m_cnt[w] = m_cnt[w] + 1;
            end else if (md == 2'b01) begin
                m_dir[w] = 1'b0;
                if (m_cnt[w] == lo) begin m_cnt[w] = hi; exp_wrap = 1'b1; end
                else m_cnt[w] = m_cnt[w] - 1;
            end else if (m_dir[w]) begin
                if (m_cnt[w] == hi) begin m_cnt[w] = hi - 1; m_dir[w] = 1'b0; exp_wrap = 1'b1; end
                else m_cnt[w] = m_cnt[w] + 1;
            end else begin
                if (m_cnt[w] == lo) begin m_cnt[w] = lo + 1; m_dir[w] = 1'b1; exp_wrap = 1'b1; end
                else m_cnt[w] = m_cnt[w] - 1;
            end
        end
    endtask

    task automatic sample(input int w);
        case (w)
            0: begin
                o_cnt = {4'h0, bus_a.count}; o_dir = bus_a.dir; o_wrap = bus_a.wrap;
                o_err = bus_a.load_err; o_hi = bus_a.at_hi; o_lo = bus_a.at_lo;
            end
            1: begin
                o_cnt = bus_b.count; o_dir = bus_b.dir; o_wrap = bus_b.wrap;
                o_err = bus_b.load_err; o_hi = bus_b.at_hi; o_lo = bus_b.at_lo;
            end
            default: begin
                o_cnt = {8'h0, bus_c.count}; o_dir = bus_c.dir; o_wrap = bus_c.wrap;
                o_err = bus_c.load_err; o_hi = bus_c.at_hi; o_lo = bus_c.at_lo;
            end
        endcase
    endtask

    task automatic check_state(input int w, input bit exp_wrap, input bit exp_err);
        sample(w);
        check($sformatf("dut%0d.count", w),    o_cnt,  int2bcd(m_cnt[w], dg_v[w]));
        check($sformatf("dut%0d.dir", w),      o_dir,  m_dir[w]);
        check($sformatf("dut%0d.wrap", w),     o_wrap, exp_wrap);
        check($sformatf("dut%0d.load_err", w), o_err,  exp_err);
        check($sformatf("dut%0d.at_hi", w),    o_hi,   m_cnt[w] == hi_v[w]);
        check($sformatf("dut%0d.at_lo", w),    o_lo,   m_cnt[w] == lo_v[w]);
    endtask

    task automatic idle_all();
        bus_a.enable = 1'b0; bus_a.load = 1'b0;
        bus_b.enable = 1'b0; bus_b.load = 1'b0;
        bus_c.enable = 1'b0; bus_c.load = 1'b0;
    endtask

    // Drive one instance for one clock, advance the model, then compare.
    task automatic step(input int w, input logic en, input logic [1:0] md,
                        input logic ld, input logic [11:0] val);
        bit exp_wrap, exp_err;
        idle_all();
        case (w)
            0: begin bus_a.enable = en; bus_a.mode = md; bus_a.load = ld; bus_a.load_val = val[7:0]; end
            1: begin bus_b.enable = en; bus_b.mode = md; bus_b.load = ld; bus_b.load_val = val; end
            default: begin bus_c.enable = en; bus_c.mode = md; bus_c.load = ld; bus_c.load_val = val[3:0]; end
        endcase
        model_step(w, en, md, ld, val, exp_wrap, exp_err);
        @(posedge clk);
        #1;
        check_state(w, exp_wrap, exp_err);
    endtask

    function automatic logic [11:0] rand_val(input int w);
        int top = hi_v[w] + 10;
        if (top > 10 ** dg_v[w] - 1) top = 10 ** dg_v[w] - 1;
        if ($urandom_range(0, 1) == 0) return int2bcd(int'($urandom_range(0, top)), dg_v[w]);
        return 12'($urandom());
    endfunction

    task automatic random_run(input int w, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(w, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 9) == 0, rand_val(w));
        end
    endtask

    initial begin
        logic [11:0] exp_b [6] = '{12'h099, 12'h098, 12'h097, 12'h096, 12'h095, 12'h210};

        reset_n = 1'b0;
        idle_all();
        bus_a.mode = 2'b00; bus_a.load_val = '0;
        bus_b.mode = 2'b00; bus_b.load_val = '0;
        bus_c.mode = 2'b00; bus_c.load_val = '0;
        model_reset();
        #12;
        for (int w = 0; w < 3; w++) check_state(w, 1'b0, 1'b0);
        reset_n = 1'b1;

        // Bounce from reset: 00 up to 31, down to 00, then back to 01.
        for (int i = 1; i <= 63; i++) begin
            step(0, 1'b1, 2'b10, 1'b0, 12'h0);
            if (i == 31) check("bounce_top", o_cnt, 12'h031);
            if (i == 32) check("bounce_rev_hi", {o_wrap, o_dir}, 12'h2);
            if (i == 62) check("bounce_bottom", o_cnt, 12'h000);
            if (i == 63) check("bounce_rev_lo", {o_cnt[7:0], o_wrap, o_dir}, 12'h007);
        end

        // Up-wrap through the upper limit.
        step(0, 1'b0, 2'b00, 1'b1, 12'h029);
        step(0, 1'b1, 2'b00, 1'b0, 12'h0);
        check("up_30", o_cnt, 12'h030);
        step(0, 1'b1, 2'b00, 1'b0, 12'h0);
        check("up_31_at_hi", {o_cnt[7:0], o_hi, o_wrap}, 12'h0C6);
        step(0, 1'b1, 2'b00, 1'b0, 12'h0);
        check("up_wrap_00", {o_cnt[7:0], o_hi, o_wrap}, 12'h001);

        // Load validation.
        step(0, 1'b0, 2'b00, 1'b1, 12'h03A);
        check("load_bad_nibble", {o_cnt[7:0], o_err}, 12'h001);
        step(0, 1'b0, 2'b00, 1'b1, 12'h045);
        check("load_above_hi", {o_cnt[7:0], o_err}, 12'h001);
        step(0, 1'b0, 2'b00, 1'b1, 12'h017);
        check("load_ok", {o_cnt[7:0], o_err}, 12'h02E);
        step(0, 1'b1, 2'b00, 1'b0, 12'h0);
        step(0, 1'b1, 2'b00, 1'b1, 12'h017);
        check("load_beats_enable", o_cnt, 12'h017);

        // Hold freezes count; load still works in hold.
        for (int i = 0; i < 10; i++) begin
            step(0, 1'b1, 2'b11, 1'b0, 12'h0);
            check("hold_frozen", o_cnt, 12'h017);
        end
        step(0, 1'b1, 2'b11, 1'b1, 12'h005);

        // Async reset between edges while a wrap pulse is high.
        step(0, 1'b0, 2'b00, 1'b1, 12'h030);
        step(0, 1'b1, 2'b00, 1'b0, 12'h0);
        step(0, 1'b1, 2'b10, 1'b0, 12'h0);
        check("pre_reset_wrap", {o_cnt[7:0], o_dir, o_wrap}, 12'h0C1);
        idle_all();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        for (int w = 0; w < 3; w++) check_state(w, 1'b0, 1'b0);
        #2 reset_n = 1'b1;

        random_run(0, 300);

        // Three-digit down-wrap with a borrow across two digits.
        step(1, 1'b0, 2'b01, 1'b1, 12'h100);
        for (int i = 0; i < 6; i++) begin
            step(1, 1'b1, 2'b01, 1'b0, 12'h0);
            check($sformatf("down3_%0d", i), o_cnt, exp_b[i]);
        end
        check("down3_wrap", o_wrap, 1'b1);
        random_run(1, 200);

        // Degenerate range: count constant, wrap on every counting tick.
        for (int md = 0; md < 3; md++) begin
            step(2, 1'b1, 2'(md), 1'b0, 12'h0);
            check("degen_tick", {o_cnt[3:0], o_dir, o_wrap}, 12'h017);
        end
        step(2, 1'b0, 2'b00, 1'b1, 12'h004);
        check("degen_load_bad", o_err, 1'b1);
        step(2, 1'b0, 2'b00, 1'b1, 12'h005);
        random_run(2, 40);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/bcd_updown_counter_n.md
# bcd_updown_counter_n

Parametrised multi-digit BCD counter with programmable lower and upper limits and four run modes: up-wrap, down-wrap, bounce (ping-pong) and hold. It also supports a synchronous parallel load and registered event pulses. It replaces fixed-range two-digit up/down counters in display and timer paths. Its packed BCD output drives the 7-segment decoders directly.

## Interface
- DIGITS, 2: number of BCD digits; count width W = 4*DIGITS.
- LIMIT_LO, 'h00: lower limit, packed BCD, W bits.
- LIMIT_HI, 'h31: upper limit, packed BCD, W bits. Must satisfy LIMIT_LO <= LIMIT_HI, with every nibble of both limits <= 9.
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- enable  in  1  count tick; one step per cycle while high.
- mode  in  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold.
- load  in  1  synchronous parallel load request.
- load_val  in  W  packed BCD value to load.
- count  out  W  packed BCD count; digit 0 (units) in [3:0].
- dir  out  1  current direction: 1 up, 0 down.
- at_hi  out  1  combinational: count == LIMIT_HI.
- at_lo  out  1  combinational: count == LIMIT_LO.
- wrap  out  1  registered 1-cycle pulse on a wrap or on a bounce reversal.
- load_err  out  1  registered 1-cycle pulse when a load is rejected.

## Operation
- **Reset values:** count = LIMIT_LO, dir = 1, wrap = 0, load_err = 0.
- **Priority** in any cycle: load, then enable, then hold.
- **Load:**
  - Accepted when every nibble of load_val is <= 9 and LIMIT_LO <= load_val <= LIMIT_HI; count <= load_val.
  - Rejected otherwise; count is unchanged and load_err pulses.
  - A load does not change dir.
  - A load in the same cycle as enable suppresses the step.
- **Digit arithmetic:**
  - Each step is ±1 in decimal.
  - Up: digit i increments when all lower digits are 9. A digit at 9 that increments becomes 0.
  - Down: digit i decrements when all lower digits are 0. A digit at 0 that decrements becomes 9.
  - Per-digit carry/borrow chain, built with a generate loop over DIGITS.
- **mode 00, up-wrap:**
  - dir <= 1 on each tick.
  - At LIMIT_HI, the next tick gives count <= LIMIT_LO and a wrap pulse.
- **mode 01, down-wrap:**
  - dir <= 0 on each tick.
  - At LIMIT_LO, the next tick gives count <= LIMIT_HI and a wrap pulse.
- **mode 10, bounce:**
  - Steps in the direction held in the dir register.
  - At LIMIT_HI with dir = 1, a tick gives count <= LIMIT_HI-1, dir <= 0, and a wrap pulse.
  - At LIMIT_LO with dir = 0, a tick gives count <= LIMIT_LO+1, dir <= 1, and a wrap pulse.
  - Each endpoint appears for exactly one tick per pass.
  - At LIMIT_HI with dir = 0, or at LIMIT_LO with dir = 1, it steps normally away from the endpoint.
- **mode 11, hold:** count and dir are frozen; enable is ignored; load still works.
- **Degenerate range:** if LIMIT_LO == LIMIT_HI, count is constant. A tick in modes 00, 01 or 10 still pulses wrap; dir is unchanged.
- **Mode change:** takes effect on the next tick, with no state flush. Entering bounce keeps the last dir.

## Timing
- Step latency is one cycle: count updates on the clk edge that samples enable = 1.
- Load latency is one cycle.
- wrap and load_err are registered. Each goes high in the cycle after the triggering edge, for exactly one cycle.
- at_hi and at_lo follow count in the same cycle.
- When reset_n goes low mid-operation, outputs go to their reset values immediately, independent of clk. Counting resumes on the first edge after reset_n is deasserted.

## Test plan
- **Reset and bounce:** DIGITS=2, LO='h00, HI='h31, mode 10, enable held high. count runs 00→31 over 31 ticks, then 30…00, then 01. wrap pulses at the 31→30 and 00→01 steps; dir falls at 31 and rises at 00.
- **Up-wrap:** mode 00, load 'h29. Ticks give 30, 31, 00. wrap pulses once, on the 31→00 step; at_hi is high only while count = 31.
- **Down-wrap with multi-digit borrow:** DIGITS=3, LO='h095, HI='h210, mode 01, load 'h100. Ticks give 099, 098, 097, 096, 095, 210, with wrap on the 095→210 step.
- **Load validation:**
  - load 'h3A (invalid nibble) is rejected: load_err pulses and count is unchanged.
  - load 'h45 (above HI) is rejected in the same way.
  - load 'h17 is accepted.
  - load together with enable gives count = 'h17 with no step.
- **Hold and async reset:**
  - mode 11 with enable high: count is frozen for 10 cycles.
  - reset_n pulsed low between clk edges: count = 'h00, dir = 1 and the pulses are 0 immediately.
